div_axis_iter: RTL and testbench

- Multi-cycle radix-2 restoring divider. It is the responder on the AXI-stream divider handshake that the EX stage drives for div/mod/divu/modu.
- It is pin-compatible with the vendor divider IP: separate dividend and divisor channels, and one result channel with no tready.
- Two instances are used in EX: SIGNED=1 for div/mod and SIGNED=0 for divu/modu. This lets the CPU build without vendor IP.

---
 rtl/div_axis_iter_pkg.sv | 18 +
 rtl/div_axis_iter_step.sv | 30 +++
 rtl/div_axis_iter.sv | 158 +++++++++++++++
 tb/tb_div_axis_iter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/div_axis_iter_pkg.sv
// Shared definitions for the iterative AXI-stream divider.
// Contents:
//   state_e   - FSM state encoding (IDLE / BUSY / DONE)
//   cnt_width - width of the step counter for a given operand width
package div_axis_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One spare bit so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_axis_iter_step.sv
// One combinational radix-2 restoring division iteration.
// Ports:
//   i_rem - partial remainder (always < i_dvs when i_dvs != 0)
//   i_quo - shifting dividend/quotient register
//   i_dvs - divisor magnitude
//   o_rem - next partial remainder
//   o_quo - next quotient register (new quotient bit shifted in at bit 0)
module div_axis_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Shifted remainder needs WIDTH+1 bits; the compare is done at that
  // width, while the difference always fits in WIDTH bits once it is taken.
  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  assign w_ge   = (w_sh >= {1'b0, i_dvs});
  assign w_diff = w_sh[WIDTH-1:0] - i_dvs;
  assign o_rem  = w_ge ? w_diff : w_sh[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_axis_iter.sv
// Multi-cycle radix-2 restoring divider with AXI-stream style channels,
// pin-compatible with the vendor divider IP.
// Ports:
//   clk, resetn                         - clock, async active-low reset
//   s_axis_dividend_{tvalid,tready,tdata} - dividend channel
//   s_axis_divisor_{tvalid,tready,tdata}  - divisor channel
//   m_axis_dout_{tvalid,tdata}          - one-cycle result pulse,
//                                         tdata = {quotient, remainder}
// Latency: result pulse WIDTH+1 cycles after the cycle in which the
// second operand handshakes. Divide by zero returns {all ones, dividend}.
module div_axis_iter
  import div_axis_iter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e             r_state;
  logic               r_flag_a, r_flag_b;
  logic               r_rdy_a, r_rdy_b;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_rem, r_quo, r_dvs;
  logic               r_sign_q, r_sign_r, r_dz;
  logic [CW-1:0]      r_cnt;
  logic               r_vld;
  logic [2*WIDTH-1:0] r_dout;

  logic               w_hs_a, w_hs_b;
  logic [WIDTH-1:0]   w_a, w_b;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt;
  logic [WIDTH-1:0]   w_q_fix, w_r_fix;
  logic [2*WIDTH-1:0] w_result;

  assign w_hs_a = s_axis_dividend_tvalid & r_rdy_a;
  assign w_hs_b = s_axis_divisor_tvalid & r_rdy_b;

  // Operands as seen on the BUSY-entry edge: a channel handshaking on that
  // very edge has not reached its capture register yet.
  assign w_a = w_hs_a ? s_axis_dividend_tdata : r_a;
  assign w_b = w_hs_b ? s_axis_divisor_tdata  : r_b;

  assign w_neg_a = (SIGNED != 0) && w_a[WIDTH-1];
  assign w_neg_b = (SIGNED != 0) && w_b[WIDTH-1];
  // Magnitude of the most negative value is itself, read as unsigned.
  assign w_mag_a = w_neg_a ? (~w_a + W_ONE) : w_a;
  assign w_mag_b = w_neg_b ? (~w_b + W_ONE) : w_b;

  div_axis_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  assign w_q_fix  = r_sign_q ? (~w_quo_nxt + W_ONE) : w_quo_nxt;
  assign w_r_fix  = r_sign_r ? (~w_rem_nxt + W_ONE) : w_rem_nxt;
  // Divide by zero bypasses the sign fix and reports the raw dividend.
  assign w_result = r_dz ? {{WIDTH{1'b1}}, r_a} : {w_q_fix, w_r_fix};

  assign s_axis_dividend_tready = r_rdy_a;
  assign s_axis_divisor_tready  = r_rdy_b;
  assign m_axis_dout_tvalid     = r_vld;
  assign m_axis_dout_tdata      = r_dout;

  // Handshake capture, iteration control and registered result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_flag_a <= 1'b0;
      r_flag_b <= 1'b0;
      r_rdy_a  <= 1'b0;
      r_rdy_b  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_vld    <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs_a) begin
            r_a      <= s_axis_dividend_tdata;
            r_flag_a <= 1'b1;
          end
          if (w_hs_b) begin
            r_b      <= s_axis_divisor_tdata;
            r_flag_b <= 1'b1;
          end
          // A channel stays closed once it holds an operand.
          r_rdy_a <= ~(r_flag_a | w_hs_a);
          r_rdy_b <= ~(r_flag_b | w_hs_b);
          if ((r_flag_a | w_hs_a) && (r_flag_b | w_hs_b)) begin
            r_state  <= ST_BUSY;
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_dvs    <= w_mag_b;
            r_sign_q <= w_neg_a ^ w_neg_b;
            r_sign_r <= w_neg_a;
            r_dz     <= (w_b == '0);
            r_cnt    <= '0;
          end
        end
        ST_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CNT_ONE;
          // The last step's result goes straight to the output register.
          if (r_cnt == CNT_LAST) begin
            r_dout  <= w_result;
            r_vld   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_flag_a <= 1'b0;
          r_flag_b <= 1'b0;
          r_rdy_a  <= 1'b1;
          r_rdy_b  <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_flag_a <= 1'b0;
          r_flag_b <= 1'b0;
          r_rdy_a  <= 1'b1;
          r_rdy_b  <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_axis_iter.sv
// Self-checking bench: one unsigned and one signed instance driven by the
// same stimulus, each compared against a plain-arithmetic division model.
module tb_div_axis_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        a_v = 1'b0, b_v = 1'b0;
  logic [31:0] a_d = 32'd0, b_d = 32'd0;

  logic        u_a_rdy, u_b_rdy, u_vld;
  logic [63:0] u_dout;
  logic        s_a_rdy, s_b_rdy, s_vld;
  logic [63:0] s_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  always #5 clk = ~clk;

  div_axis_iter #(.WIDTH(32), .SIGNED(0)) u_dut (
    .clk(clk), .resetn(resetn),
    .s_axis_dividend_tvalid(a_v), .s_axis_dividend_tready(u_a_rdy), .s_axis_dividend_tdata(a_d),
    .s_axis_divisor_tvalid(b_v),  .s_axis_divisor_tready(u_b_rdy),  .s_axis_divisor_tdata(b_d),
    .m_axis_dout_tvalid(u_vld), .m_axis_dout_tdata(u_dout)
  );

  div_axis_iter #(.WIDTH(32), .SIGNED(1)) s_dut (
    .clk(clk), .resetn(resetn),
    .s_axis_dividend_tvalid(a_v), .s_axis_dividend_tready(s_a_rdy), .s_axis_dividend_tdata(a_d),
    .s_axis_divisor_tvalid(b_v),  .s_axis_divisor_tready(s_b_rdy),  .s_axis_divisor_tdata(b_d),
    .m_axis_dout_tvalid(s_vld), .m_axis_dout_tdata(s_dout)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, div-by-zero gives {ones, dividend}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic tick;
    @(negedge clk);
    ncyc++;
  endtask

  // Offer a/b after da/db cycles; if pre, offer na/nb as soon as both are
  // taken. Returns at the negedge of cycle T+34 (T = handshake cycle).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int da, input int db,
                       input bit pre, input logic [31:0] na, input logic [31:0] nb,
                       output int t_o);
    bit          got_a, got_b;
    int          t, pu, ps, viol;
    logic [63:0] eu, es, du, ds;
    got_a = 1'b0; got_b = 1'b0;
    t = -1; pu = -1; ps = -1; viol = 0;
    du = 64'd0; ds = 64'd0;
    eu = ref_div(a, b, 1'b0);
    es = ref_div(a, b, 1'b1);
    for (int k = 0; k < 150; k++) begin
      if (t >= 0 && ncyc == t + 34) break;
      if (!got_a) begin a_v = (k >= da); a_d = a; end
      else if (pre && got_b) begin a_v = 1'b1; a_d = na; end
      else a_v = 1'b0;
      if (!got_b) begin b_v = (k >= db); b_d = b; end
      else if (pre && got_a) begin b_v = 1'b1; b_d = nb; end
      else b_v = 1'b0;
      if (got_a && (u_a_rdy || s_a_rdy)) viol++;
      if (got_b && (u_b_rdy || s_b_rdy)) viol++;
      if (a_v && u_a_rdy && !got_a) got_a = 1'b1;
      if (b_v && u_b_rdy && !got_b) got_b = 1'b1;
      if (got_a && got_b && t < 0) t = ncyc;
      if (u_vld) begin
        if (pu < 0 && t >= 0) begin pu = ncyc; du = u_dout; end
        else viol++;
      end
      if (s_vld) begin
        if (ps < 0 && t >= 0) begin ps = ncyc; ds = s_dout; end
        else viol++;
      end
      tick;
    end
    t_o = t;
    check_eq("handshake", 64'(t >= 0), 64'd1);
    check_eq("lat_u", 64'(pu - t), 64'd33);
    check_eq("lat_s", 64'(ps - t), 64'd33);
    check_eq("dout_u", du, eu);
    check_eq("dout_s", ds, es);
    check_eq("hold_u", u_dout, eu);
    check_eq("hold_s", s_dout, es);
    check_eq("rdy_back", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'hF);
    check_eq("vld_once", {62'd0, u_vld, s_vld}, 64'd0);
    check_eq("rdy_hold", 64'(viol), 64'd0);
  endtask

  initial begin
    int t1, t2, npulse;
    logic [31:0] ra, rb;

    // Reset state while resetn is held low.
    tick; tick;
    check_eq("rst_rdy", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'd0);
    check_eq("rst_vld", {62'd0, u_vld, s_vld}, 64'd0);
    check_eq("rst_dout", u_dout | s_dout, 64'd0);
    resetn = 1'b1;
    tick;
    check_eq("rst_rel_rdy", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'hF);

    // Directed vectors.
    do_op(32'd100,        32'd7,          0, 0, 1'b0, 32'd0, 32'd0, t1);
    check_eq("vec_100_7", u_dout, 64'h0000000E_00000002);
    do_op(32'hFFFF_FFF9,  32'd2,          0, 0, 1'b0, 32'd0, 32'd0, t1);
    check_eq("vec_m7_2", s_dout, 64'hFFFFFFFD_FFFFFFFF);
    do_op(32'd7,          32'hFFFF_FFFE,  0, 0, 1'b0, 32'd0, 32'd0, t1);
    check_eq("vec_7_m2", s_dout, 64'hFFFFFFFD_00000001);
    do_op(32'h8000_0000,  32'hFFFF_FFFF,  0, 0, 1'b0, 32'd0, 32'd0, t1);
    check_eq("vec_min_m1", s_dout, 64'h80000000_00000000);
    do_op(32'hFFFF_FFFF,  32'd1,          0, 0, 1'b0, 32'd0, 32'd0, t1);
    check_eq("vec_max_1", u_dout, 64'hFFFFFFFF_00000000);
    do_op(32'd5,          32'd0,          0, 0, 1'b0, 32'd0, 32'd0, t1);
    check_eq("vec_5_0", u_dout, 64'hFFFFFFFF_00000005);
    do_op(32'hFFFF_FFFB,  32'd0,          0, 0, 1'b0, 32'd0, 32'd0, t1);
    check_eq("vec_m5_0", s_dout, 64'hFFFFFFFF_FFFFFFFB);

    // Staggered channels, both orders.
    do_op(32'd12345,      32'd67,         0, 3, 1'b0, 32'd0, 32'd0, t1);
    do_op(32'hDEAD_BEEF,  32'hFFFF_0003,  4, 1, 1'b0, 32'd0, 32'd0, t1);

    // New operands held valid throughout BUSY/DONE.
    do_op(32'd1000,       32'd33,         0, 0, 1'b1, 32'hFFFF_FF00, 32'd5, t1);
    do_op(32'hFFFF_FF00,  32'd5,          0, 0, 1'b0, 32'd0, 32'd0, t2);
    check_eq("blk_next_hs", 64'(t2 - t1), 64'd34);

    // Randomized operands and channel timing.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = (($urandom_range(0, 1) == 0) ? 32'd0 : 32'(1 + $urandom_range(0, 15)));
        1:       rb = 32'(1 + $urandom_range(0, 1000));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 100));
        default: rb = $urandom;
      endcase
      do_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 32'd0, 32'd0, t1);
    end

    // Asynchronous reset in the middle of an operation.
    a_v = 1'b1; a_d = 32'd999; b_v = 1'b1; b_d = 32'd3;
    tick;
    a_v = 1'b0; b_v = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_rdy", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'd0);
    check_eq("arst_vld", {62'd0, u_vld, s_vld}, 64'd0);
    check_eq("arst_dout", u_dout | s_dout, 64'd0);
    tick;
    resetn = 1'b1;
    tick;
    check_eq("arst_rel_rdy", {60'd0, u_a_rdy, u_b_rdy, s_a_rdy, s_b_rdy}, 64'hF);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      if (u_vld || s_vld) npulse++;
      tick;
    end
    check_eq("arst_no_pulse", 64'(npulse), 64'd0);

    // Divider still operational after the abort.
    do_op(32'd81, 32'd9, 0, 0, 1'b0, 32'd0, 32'd0, t1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
